// File: rtl/dds_trigger_loader.sv
// dds_trigger_loader
// Turns each accepted rising edge of an upstream trigger into one complete
// DDS reprogram. The sequence is: latch {INSTR, ftw_in}, shift it out
// MSB-first on a 3-wire bus (csb/sclk/sdio), then pulse io_update.
// Triggers that arrive while a sequence is running are counted, not queued.
// Every output comes straight from a register, so no output can glitch.

module dds_trigger_loader #(
    parameter int unsigned DATA_BITS     = 32,
    parameter logic [7:0]  INSTR         = 8'h02,
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned UPDATE_CYCLES = 4
) (
    input  logic                 int_clock,
    input  logic                 reset,
    input  logic                 trigger_in,
    input  logic [DATA_BITS-1:0] ftw_in,
    output logic                 dds_sclk,
    output logic                 dds_sdio,
    output logic                 dds_csb,
    output logic                 dds_io_update,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           missed_count
);

    // Total frame length: instruction byte plus tuning word.
    localparam int unsigned N       = 8 + DATA_BITS;
    localparam int unsigned CNT_MAX = (CLK_DIV > UPDATE_CYCLES) ? CLK_DIV : UPDATE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned BIT_W   = $clog2(N + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] UPD_LAST = CNT_W'(UPDATE_CYCLES - 1);
    localparam logic [BIT_W-1:0] BITS_ALL = BIT_W'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_trig_prev;
    logic [N-1:0]     r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_sclk;
    logic             r_sdio;
    logic             r_csb;
    logic             r_io_update;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_missed;

    state_t           w_state_nxt;
    logic [N-1:0]     w_shift_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [BIT_W-1:0] w_bit_cnt_nxt;
    logic             w_sclk_nxt;
    logic             w_sdio_nxt;
    logic             w_csb_nxt;
    logic             w_io_update_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [7:0]       w_missed_nxt;
    logic             w_rise;
    logic             w_div_last;

    assign w_rise     = trigger_in & ~r_trig_prev;
    assign w_div_last = (r_cnt == DIV_LAST);

    // Next-state and next-output decode for the load/shift/update sequence.
    // NOTE: every signal gets its default first, so no path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_sclk_nxt      = r_sclk;
        w_csb_nxt       = r_csb;
        w_io_update_nxt = r_io_update;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt   = S_SETUP;
                    w_shift_nxt   = {INSTR, ftw_in};
                    w_bit_cnt_nxt = '0;
                    w_busy_nxt    = 1'b1;
                    w_csb_nxt     = 1'b0;
                end
            end
            S_SETUP: begin
                // csb low with MSB on sdio for one half-period before the first sclk rise.
                if (w_div_last) begin
                    w_state_nxt = S_SHIFT;
                    w_sclk_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            S_SHIFT: begin
                if (w_div_last) begin
                    w_cnt_nxt = '0;
                    if (r_sclk) begin
                        // Falling edge: present the next bit (zero after the last one).
                        w_sclk_nxt    = 1'b0;
                        w_shift_nxt   = {r_shift[N-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end else if (r_bit_cnt == BITS_ALL) begin
                        w_state_nxt = S_HOLD;
                        w_csb_nxt   = 1'b1;
                    end else begin
                        w_sclk_nxt = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (w_div_last) begin
                    w_state_nxt     = S_UPDATE;
                    w_io_update_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                end
            end
            S_UPDATE: begin
                if (r_cnt == UPD_LAST) begin
                    w_state_nxt     = S_DONE;
                    w_io_update_nxt = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_cnt_nxt       = '0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_sclk_nxt      = 1'b0;
                w_csb_nxt       = 1'b1;
                w_io_update_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
                w_cnt_nxt       = '0;
            end
        endcase

        // sdio always mirrors the MSB of the frame while the bus is selected.
        w_sdio_nxt = ((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT)) ? w_shift_nxt[N-1] : 1'b0;

        // Any rise outside IDLE (which includes the DONE cycle) is a missed trigger.
        w_missed_nxt = r_missed;
        if (w_rise && (r_state != S_IDLE) && (r_missed != 8'hFF)) begin
            w_missed_nxt = r_missed + 8'd1;
        end
    end

    // State and output registers; reset aborts any sequence in progress.
    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge int_clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_trig_prev <= 1'b1;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_sclk      <= 1'b0;
            r_sdio      <= 1'b0;
            r_csb       <= 1'b1;
            r_io_update <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_missed    <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_trig_prev <= trigger_in;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_sclk      <= w_sclk_nxt;
            r_sdio      <= w_sdio_nxt;
            r_csb       <= w_csb_nxt;
            r_io_update <= w_io_update_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_missed    <= w_missed_nxt;
        end
    end

    assign dds_sclk      = r_sclk;
    assign dds_sdio      = r_sdio;
    assign dds_csb       = r_csb;
    assign dds_io_update = r_io_update;
    assign busy          = r_busy;
    assign done          = r_done;
    assign missed_count  = r_missed;

endmodule

// File: tb/tb_dds_trigger_loader.sv
// Testbench for dds_trigger_loader.
// A bus monitor reconstructs each frame from sclk rising edges and times
// csb/io_update/done; results are compared against the frame and timing
// that the protocol rules predict for the chosen parameters.

module tb_dds_trigger_loader;

    localparam int          DATA_BITS = 32;
    localparam logic [7:0]  INSTR     = 8'h02;
    localparam int          CLK_DIV   = 2;
    localparam int          UPD       = 4;
    localparam int          N         = 8 + DATA_BITS;
    localparam int          CSB_LOW   = CLK_DIV * (1 + 2 * N);
    localparam int          SLOW_DIV  = 100;

    logic                 int_clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 trigger_in = 1'b0;
    logic [DATA_BITS-1:0] ftw_in = '0;
    logic                 dds_sclk, dds_sdio, dds_csb, dds_io_update, busy, done;
    logic [7:0]           missed_count;

    logic                 trigger_slow = 1'b0;
    logic [DATA_BITS-1:0] ftw_slow = 32'h0BAD_F00D;
    logic                 sclk_slow, sdio_slow, csb_slow, upd_slow, busy_slow, done_slow;
    logic [7:0]           missed_slow;

    int total = 0;
    int bad   = 0;
    int exp_missed = 0;

    // Bus monitor state.
    int          tk;
    int          rise_cnt;
    logic [63:0] rx;
    int          csb_low;
    int          csb_rise_tk;
    int          upd_cnt;
    int          upd_first_tk;
    int          done_cnt;
    int          done_tk;
    logic        busy_at_done;
    logic        busy_after_done;
    logic        prev_sclk, prev_csb, prev_upd, prev_done;

    always #5 int_clock = ~int_clock;

    dds_trigger_loader #(
        .DATA_BITS(DATA_BITS), .INSTR(INSTR), .CLK_DIV(CLK_DIV), .UPDATE_CYCLES(UPD)
    ) u_dut (
        .int_clock(int_clock), .reset(reset), .trigger_in(trigger_in), .ftw_in(ftw_in),
        .dds_sclk(dds_sclk), .dds_sdio(dds_sdio), .dds_csb(dds_csb),
        .dds_io_update(dds_io_update), .busy(busy), .done(done), .missed_count(missed_count)
    );

    dds_trigger_loader #(
        .DATA_BITS(DATA_BITS), .INSTR(INSTR), .CLK_DIV(SLOW_DIV), .UPDATE_CYCLES(UPD)
    ) u_dut_slow (
        .int_clock(int_clock), .reset(reset), .trigger_in(trigger_slow), .ftw_in(ftw_slow),
        .dds_sclk(sclk_slow), .dds_sdio(sdio_slow), .dds_csb(csb_slow),
        .dds_io_update(upd_slow), .busy(busy_slow), .done(done_slow), .missed_count(missed_slow)
    );

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic clear_stats();
        tk = 0; rise_cnt = 0; rx = '0; csb_low = 0; csb_rise_tk = -1;
        upd_cnt = 0; upd_first_tk = -1; done_cnt = 0; done_tk = -1;
        busy_at_done = 1'bx; busy_after_done = 1'bx;
        prev_sclk = dds_sclk; prev_csb = dds_csb; prev_upd = dds_io_update; prev_done = done;
    endtask

    // One clock: sample on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge int_clock);
        if (dds_sclk === 1'b1 && prev_sclk === 1'b0) begin
            rise_cnt++;
            rx = {rx[62:0], dds_sdio};
        end
        if (dds_csb === 1'b0) csb_low++;
        if (dds_csb === 1'b1 && prev_csb === 1'b0 && csb_rise_tk < 0) csb_rise_tk = tk;
        if (dds_io_update === 1'b1) upd_cnt++;
        if (dds_io_update === 1'b1 && prev_upd === 1'b0 && upd_first_tk < 0) upd_first_tk = tk;
        if (prev_done === 1'b1) busy_after_done = busy;
        if (done === 1'b1) begin
            done_cnt++;
            done_tk = tk;
            busy_at_done = busy;
        end
        prev_sclk = dds_sclk; prev_csb = dds_csb; prev_upd = dds_io_update; prev_done = done;
        tk++;
    endtask

    // One triggered transfer, checked against the frame and timing the rules predict.
    task automatic run_transfer(input logic [31:0] ftw, input logic [31:0] ftw_late,
                                input int pulse_len, input int n_extra, input int pre_idle,
                                input bit rise_in_done, input string name);
        int           ex_start[4];
        int           ex_len[4];
        logic         lvl;
        logic [N-1:0] exp_bits;
        int           budget;
        exp_bits = {INSTR, ftw};
        budget   = CSB_LOW + CLK_DIV + UPD + 20;
        for (int j = 0; j < 4; j++) begin
            ex_start[j] = 40 + j * 20 + int'($urandom_range(0, 5));
            ex_len[j]   = int'($urandom_range(1, 4));
        end
        for (int i = 0; i < pre_idle; i++) begin
            trigger_in = 1'b0;
            tick();
        end
        clear_stats();
        ftw_in = ftw;
        for (int t = 0; t < budget; t++) begin
            lvl = (t < pulse_len);
            for (int j = 0; j < n_extra; j++)
                if (t >= ex_start[j] && t < ex_start[j] + ex_len[j]) lvl = 1'b1;
            if (rise_in_done && done_cnt > 0) lvl = 1'b1;
            trigger_in = lvl;
            if (t == 1) ftw_in = ftw_late;
            tick();
            if (t == 0) begin
                total++;
                if ({dds_csb, busy} !== 2'b01) begin
                    bad++;
                    $display("FAIL %s start: csb,busy=%b required 01", name, {dds_csb, busy});
                end
            end
            if (done_cnt > 0 && tk == done_tk + 2) break;
        end
        exp_missed = sat255(exp_missed + n_extra + (rise_in_done ? 1 : 0));

        total++;
        if (rise_cnt !== N) begin
            bad++; $display("FAIL %s sclk_rises: got %0d required %0d", name, rise_cnt, N);
        end
        total++;
        if (rx[N-1:0] !== exp_bits) begin
            bad++; $display("FAIL %s frame: got %h required %h", name, rx[N-1:0], exp_bits);
        end
        total++;
        if (csb_low !== CSB_LOW) begin
            bad++; $display("FAIL %s csb_low: got %0d required %0d", name, csb_low, CSB_LOW);
        end
        total++;
        if (csb_rise_tk !== CSB_LOW) begin
            bad++; $display("FAIL %s csb_rise_at: got %0d required %0d", name, csb_rise_tk, CSB_LOW);
        end
        total++;
        if (upd_cnt !== UPD) begin
            bad++; $display("FAIL %s io_update_len: got %0d required %0d", name, upd_cnt, UPD);
        end
        total++;
        if (upd_first_tk - csb_rise_tk !== CLK_DIV) begin
            bad++; $display("FAIL %s io_update_gap: got %0d required %0d", name,
                            upd_first_tk - csb_rise_tk, CLK_DIV);
        end
        total++;
        if (done_cnt !== 1) begin
            bad++; $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt);
        end
        total++;
        if (done_tk !== CSB_LOW + CLK_DIV + UPD) begin
            bad++; $display("FAIL %s done_at: got %0d required %0d", name, done_tk, CSB_LOW + CLK_DIV + UPD);
        end
        total++;
        if (busy_at_done !== 1'b1) begin
            bad++; $display("FAIL %s busy_in_done: got %b required 1", name, busy_at_done);
        end
        total++;
        if (busy_after_done !== 1'b0) begin
            bad++; $display("FAIL %s busy_after_done: got %b required 0", name, busy_after_done);
        end
        total++;
        if (missed_count !== 8'(exp_missed)) begin
            bad++; $display("FAIL %s missed_count: got %0d required %0d", name, missed_count, exp_missed);
        end
    endtask

    task automatic test_reset();
        trigger_in = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({dds_sclk, dds_sdio, dds_csb, dds_io_update, busy, done, missed_count} !== {6'b001000, 8'd0}) begin
            bad++;
            $display("FAIL reset_values: sclk,sdio,csb,upd,busy,done=%b missed=%0d required 001000 0",
                     {dds_sclk, dds_sdio, dds_csb, dds_io_update, busy, done}, missed_count);
        end
        reset = 1'b0;
        exp_missed = 0;
        clear_stats();
        repeat (50) tick();
        total++;
        if (csb_low !== 0) begin
            bad++; $display("FAIL held_trigger_csb: low cycles %0d required 0", csb_low);
        end
        total++;
        if ({busy, missed_count} !== 9'd0) begin
            bad++; $display("FAIL held_trigger_idle: busy=%b missed=%0d required 0 0", busy, missed_count);
        end
        trigger_in = 1'b0;
    endtask

    task automatic test_basic_load();
        run_transfer(32'h1234ABCD, 32'hFFFFFFFF, 25, 0, 2, 1'b0, "basic");
    endtask

    task automatic test_random_loads();
        for (int i = 0; i < 4; i++)
            run_transfer($urandom, $urandom, int'($urandom_range(1, 25)), 0, int'($urandom_range(1, 6)),
                         1'b0, "random");
    endtask

    task automatic test_missed_shift();
        run_transfer($urandom, $urandom, 25, 2, 2, 1'b0, "missed_two");
        run_transfer($urandom, $urandom, 5, 4, 3, 1'b0, "missed_four");
    endtask

    task automatic test_mid_reset();
        logic [31:0] ftw;
        bit          hit;
        ftw = $urandom;
        trigger_in = 1'b0;
        tick(); tick();
        clear_stats();
        ftw_in = ftw;
        hit = 1'b0;
        for (int t = 0; t < 300; t++) begin
            trigger_in = (t < 5);
            tick();
            if (rise_cnt == 17) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL mid_reset_reach17: sclk rises %0d required 17", rise_cnt);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({dds_csb, dds_sclk, busy, dds_io_update, done} !== 5'b10000) begin
            bad++; $display("FAIL mid_reset_abort: csb,sclk,busy,upd,done=%b required 10000",
                            {dds_csb, dds_sclk, busy, dds_io_update, done});
        end
        reset = 1'b0;
        exp_missed = 0;
        clear_stats();
        repeat (200) tick();
        total++;
        if ({upd_cnt, done_cnt, csb_low} !== {32'd0, 32'd0, 32'd0}) begin
            bad++; $display("FAIL mid_reset_quiet: upd=%0d done=%0d csb_low=%0d required 0 0 0",
                            upd_cnt, done_cnt, csb_low);
        end
        run_transfer($urandom, $urandom, 10, 0, 2, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_transfer($urandom, $urandom, 3, 0, 2, 1'b1, "rise_in_done");
        clear_stats();
        repeat (10) tick();
        total++;
        if (csb_low !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rise_in_done_ignored: csb_low=%0d busy=%b required 0 0", csb_low, busy);
        end
        trigger_in = 1'b0;
        run_transfer($urandom, $urandom, 3, 0, 2, 1'b0, "b2b_first");
        run_transfer($urandom, $urandom, 3, 0, 0, 1'b0, "b2b_first_idle");
    endtask

    task automatic test_saturation();
        int model;
        trigger_slow = 1'b1; tick();
        trigger_slow = 1'b0; tick();
        total++;
        if (busy_slow !== 1'b1) begin
            bad++; $display("FAIL slow_start: busy=%b required 1", busy_slow);
        end
        model = 0;
        for (int i = 0; i < 300; i++) begin
            trigger_slow = 1'b1; tick();
            trigger_slow = 1'b0; tick();
            model = sat255(model + 1);
            if (i == 99 || i == 253 || i == 254 || i == 299) begin
                total++;
                if (missed_slow !== 8'(model)) begin
                    bad++; $display("FAIL saturate_%0d: got %0d required %0d", i + 1, missed_slow, model);
                end
            end
        end
        total++;
        if ({busy_slow, csb_slow, done_slow} !== 3'b100) begin
            bad++; $display("FAIL slow_single_transfer: busy,csb,done=%b required 100",
                            {busy_slow, csb_slow, done_slow});
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_random_loads();
        test_missed_shift();
        test_mid_reset();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
